spio_spinnaker_link_sender_buf: RTL and testbench

Parametrised, buffered SpiNNaker link transmitter. It accepts packets on a synchronous valid/ready interface into an internal FIFO. Each packet is serialised as NRZ 2-of-7 symbols, one nibble per symbol, least-significant nibble first, followed by an EOP symbol, on the asynchronous SpiNNaker link. It adds an ack synchroniser, a stall timeout with a sticky error flag, a send enable, and counters for packets and symbols.

---
 rtl/spio_spinnaker_link_sender_buf.sv | 254 +++++++++++++++++++++++++
 tb/tb_spio_spinnaker_link_sender_buf.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spio_spinnaker_link_sender_buf.sv
// Buffered SpiNNaker link transmitter: a packet FIFO feeding a 2-of-7 NRZ serialiser
// with an ack synchroniser, a stall timeout and packet/symbol counters.
module spio_spinnaker_link_sender_buf #(
    parameter int unsigned PKT_BITS       = 72,
    parameter int unsigned SHORT_BITS     = 40,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_BITS       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [PKT_BITS-1:0] pkt_data,
    input  logic                pkt_vld,
    output logic                pkt_rdy,
    output logic [6:0]          data_2of7,
    input  logic                ack,
    output logic                ctr_pkt,
    output logic                busy,
    output logic                timeout_err,
    input  logic                timeout_clr,
    output logic [CNT_BITS-1:0] pkt_count,
    output logic [CNT_BITS-1:0] sym_count
);

    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned NW  = $clog2(PKT_BITS / 4 + 1);
    localparam int unsigned STW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [AW:0]     FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [NW-1:0]   N_LONG   = NW'(PKT_BITS / 4);
    localparam logic [NW-1:0]   N_SHORT  = NW'(SHORT_BITS / 4);
    localparam logic [STW-1:0]  TO_CNT   = STW'(TIMEOUT_CYCLES);
    localparam logic [6:0]      EOP_CODE = 7'h60;

    typedef enum logic [1:0] {StIdle, StTran, StEopWait} state_e;

    function automatic logic [6:0] nib_code(input logic [3:0] nib);
        logic [6:0] c;
        case (nib)
            4'h0: c = 7'h11;
            4'h1: c = 7'h12;
            4'h2: c = 7'h14;
            4'h3: c = 7'h18;
            4'h4: c = 7'h21;
            4'h5: c = 7'h22;
            4'h6: c = 7'h24;
            4'h7: c = 7'h28;
            4'h8: c = 7'h41;
            4'h9: c = 7'h42;
            4'hA: c = 7'h44;
            4'hB: c = 7'h48;
            4'hC: c = 7'h03;
            4'hD: c = 7'h06;
            4'hE: c = 7'h0C;
            default: c = 7'h09;
        endcase
        return c;
    endfunction

    // Ack synchroniser
    logic ack_s;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign ack_s = ack;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q, sync_d;

        always_comb begin
            sync_d[0] = ack;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_d[i] = sync_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) sync_q <= '0;
            else     sync_q <= sync_d;
        end

        assign ack_s = sync_q[SYNC_STAGES-1];
    end

    // Input FIFO
    logic [PKT_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]         cnt_q, cnt_d;
    logic                pkt_rdy_q, pkt_rdy_d;
    logic                wr_en, pop, empty;
    logic [PKT_BITS-1:0] head;

    assign wr_en = pkt_vld && pkt_rdy_q;
    assign empty = (cnt_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
        pkt_rdy_d = (cnt_d != FULL_CNT);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= pkt_data;
    end

    // Serialiser state
    state_e              state_q, state_d;
    logic [6:0]          data_q, data_d;
    logic                old_ack_q, old_ack_d;
    logic [PKT_BITS-1:0] shift_q, shift_d;
    logic                long_q, long_d;
    logic [NW-1:0]       n_q, n_d, n_last;
    logic                ctr_pkt_q;
    logic [STW-1:0]      stall_q, stall_d;
    logic                err_q, err_d;
    logic [CNT_BITS-1:0] pkt_cnt_q, pkt_cnt_d, sym_cnt_q, sym_cnt_d;
    logic                tr, start, sym_drive, eop_drive, pkt_done;

    assign tr     = (ack_s != old_ack_q);
    assign start  = !empty && enable;
    assign n_last = long_q ? N_LONG : N_SHORT;

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (start) state_d = StTran;
            StTran:    if (tr && n_q == n_last) state_d = StEopWait;
            StEopWait: if (tr) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        pop       = 1'b0;
        sym_drive = 1'b0;
        eop_drive = 1'b0;
        pkt_done  = 1'b0;
        data_d    = data_q;
        old_ack_d = old_ack_q;
        shift_d   = shift_q;
        long_d    = long_q;
        n_d       = n_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    pop       = 1'b1;
                    sym_drive = 1'b1;
                    data_d    = data_q ^ nib_code(head[3:0]);
                    old_ack_d = ack_s;
                    shift_d   = head >> 4;
                    long_d    = head[1];
                    n_d       = NW'(1);
                end
            end
            StTran: begin
                if (tr) begin
                    old_ack_d = ack_s;
                    sym_drive = 1'b1;
                    if (n_q == n_last) begin
                        eop_drive = 1'b1;
                        data_d    = data_q ^ EOP_CODE;
                    end else begin
                        data_d  = data_q ^ nib_code(shift_q[3:0]);
                        shift_d = shift_q >> 4;
                        n_d     = n_q + NW'(1);
                    end
                end
            end
            StEopWait: begin
                if (tr) begin
                    old_ack_d = ack_s;
                    pkt_done  = 1'b1;
                end
            end
            default: ;
        endcase

        // Stall counter saturates at the limit; clear beats a coincident new timeout
        if (timeout_clr || state_q == StIdle || tr) begin
            stall_d = '0;
        end else if (stall_q != TO_CNT) begin
            stall_d = stall_q + STW'(1);
        end else begin
            stall_d = stall_q;
        end

        if (timeout_clr) begin
            err_d = 1'b0;
        end else if (TIMEOUT_CYCLES != 0 && stall_d == TO_CNT) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        pkt_cnt_d = pkt_done ? pkt_cnt_q + CNT_BITS'(1) : pkt_cnt_q;
        sym_cnt_d = sym_drive ? sym_cnt_q + CNT_BITS'(1) : sym_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            pkt_rdy_q <= 1'b0;
            data_q    <= '0;
            old_ack_q <= 1'b0;
            shift_q   <= '0;
            long_q    <= 1'b0;
            n_q       <= '0;
            ctr_pkt_q <= 1'b0;
            stall_q   <= '0;
            err_q     <= 1'b0;
            pkt_cnt_q <= '0;
            sym_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            pkt_rdy_q <= pkt_rdy_d;
            data_q    <= data_d;
            old_ack_q <= old_ack_d;
            shift_q   <= shift_d;
            long_q    <= long_d;
            n_q       <= n_d;
            ctr_pkt_q <= eop_drive;
            stall_q   <= stall_d;
            err_q     <= err_d;
            pkt_cnt_q <= pkt_cnt_d;
            sym_cnt_q <= sym_cnt_d;
        end
    end

    always_comb begin
        pkt_rdy     = pkt_rdy_q;
        data_2of7   = data_q;
        ctr_pkt     = ctr_pkt_q;
        busy        = (state_q != StIdle) || !empty;
        timeout_err = err_q;
        pkt_count   = pkt_cnt_q;
        sym_count   = sym_cnt_q;
    end

endmodule

// File: tb/tb_spio_spinnaker_link_sender_buf.sv
// Directed bench for the buffered SpiNNaker link sender with a loopback ack responder
// and a symbol monitor that records every data_2of7 update.
module tb_spio_spinnaker_link_sender_buf;

    logic        clk = 1'b0;
    logic        rst, enable, pkt_vld, ack, timeout_clr;
    logic [71:0] pkt_data;
    logic        pkt_rdy, ctr_pkt, busy, timeout_err;
    logic [6:0]  data_2of7;
    logic [31:0] pkt_count, sym_count;

    int passed = 0;
    int total  = 0;
    int stray  = 0;
    bit ack_en = 1'b0;
    logic [6:0] rsp_prev = 7'h00;
    logic [6:0] mon_prev = 7'h00;
    logic [6:0] codes[$];
    bit         ctrs[$];

    spio_spinnaker_link_sender_buf dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .pkt_data   (pkt_data),
        .pkt_vld    (pkt_vld),
        .pkt_rdy    (pkt_rdy),
        .data_2of7  (data_2of7),
        .ack        (ack),
        .ctr_pkt    (ctr_pkt),
        .busy       (busy),
        .timeout_err(timeout_err),
        .timeout_clr(timeout_clr),
        .pkt_count  (pkt_count),
        .sym_count  (sym_count)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Loopback receiver: toggle ack about 3 cycles after each new symbol
    initial begin
        ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (ack_en && data_2of7 !== rsp_prev) begin
                rsp_prev = data_2of7;
                repeat (2) @(posedge clk);
                #1 ack = ~ack;
            end
        end
    end

    // Record each symbol as the xor of successive link states
    initial begin
        forever begin
            @(posedge clk); #1;
            if (data_2of7 !== mon_prev) begin
                if (!rst && $countones(data_2of7 ^ mon_prev) != 2) stray++;
                codes.push_back(data_2of7 ^ mon_prev);
                ctrs.push_back(ctr_pkt);
                mon_prev = data_2of7;
            end else if (ctr_pkt) begin
                stray++;
            end
        end
    end

    function automatic logic [6:0] code_of(input logic [3:0] v);
        case (v)
            4'h0: return 7'h11;  4'h1: return 7'h12;  4'h2: return 7'h14;  4'h3: return 7'h18;
            4'h4: return 7'h21;  4'h5: return 7'h22;  4'h6: return 7'h24;  4'h7: return 7'h28;
            4'h8: return 7'h41;  4'h9: return 7'h42;  4'hA: return 7'h44;  4'hB: return 7'h48;
            4'hC: return 7'h03;  4'hD: return 7'h06;  4'hE: return 7'h0C;  default: return 7'h09;
        endcase
    endfunction

    // Expected symbols for one packet starting at codes[base]
    function automatic bit seq_ok(input int base, input logic [71:0] p, input bit lng);
        int nn;
        nn = lng ? 18 : 10;
        if (codes.size() < base + nn + 1) return 1'b0;
        for (int i = 0; i < nn; i++) begin
            if (codes[base+i] !== code_of(p[4*i +: 4]) || ctrs[base+i]) return 1'b0;
        end
        if (codes[base+nn] !== 7'h60 || !ctrs[base+nn]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic send(input logic [71:0] p);
        int k;
        pkt_data = p;
        pkt_vld  = 1'b1;
        k = 0;
        while (!pkt_rdy && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        total++;
        if (k >= 2000) $display("FAIL send: pkt_rdy stuck low, got %0d cycles required <2000", k);
        else passed++;
        @(posedge clk); #1;
        pkt_vld = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (busy && k < 5000);
        total++;
        if (busy !== 1'b0) $display("FAIL %s_idle: busy=%b required 0", nm, busy);
        else passed++;
    endtask

    task automatic wait_syms(input int n, input string nm);
        int k;
        k = 0;
        while (codes.size() < n && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        total++;
        if (codes.size() < n) $display("FAIL %s_syms: got %0d symbols required %0d", nm, codes.size(), n);
        else passed++;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %h required %h", nm, got, exp);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; pkt_vld = 1'b0; timeout_clr = 1'b0; pkt_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pkt_rdy", 32'(pkt_rdy), 32'd0);
        chk("rst_data", 32'(data_2of7), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);
        chk("rst_ctr", 32'(ctr_pkt), 32'd0);
        chk("rst_pkt_count", pkt_count, 32'd0);
        chk("rst_sym_count", sym_count, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_pkt_rdy", 32'(pkt_rdy), 32'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_short();
        codes.delete(); ctrs.delete();
        ack_en = 1'b1;
        send(72'h0);
        wait_idle("short");
        chk("short_nsym", 32'(codes.size()), 32'd11);
        chk("short_first", 32'(codes[0]), 32'h11);
        chk("short_seq", 32'(seq_ok(0, 72'h0, 1'b0)), 32'd1);
        chk("short_pkt_count", pkt_count, 32'd1);
        chk("short_sym_count", sym_count, 32'd11);
    endtask

    task automatic test_long();
        codes.delete(); ctrs.delete();
        send(72'h123456789ABCDEF0F2);
        wait_idle("long");
        chk("long_nsym", 32'(codes.size()), 32'd19);
        chk("long_second", 32'(codes[1]), 32'h09);
        chk("long_seq", 32'(seq_ok(0, 72'h123456789ABCDEF0F2, 1'b1)), 32'd1);
        chk("long_pkt_count", pkt_count, 32'd2);
        chk("long_sym_count", sym_count, 32'd30);
    endtask

    task automatic test_short_payload();
        codes.delete(); ctrs.delete();
        send(72'hABCDEF001234500009);
        wait_idle("payload");
        chk("payload_nsym", 32'(codes.size()), 32'd11);
        chk("payload_seq", 32'(seq_ok(0, 72'hABCDEF001234500009, 1'b0)), 32'd1);
        chk("payload_pkt_count", pkt_count, 32'd3);
    endtask

    task automatic test_back_to_back();
        logic [3:0] v[5];
        v[0] = 4'h1; v[1] = 4'h4; v[2] = 4'h5; v[3] = 4'h8; v[4] = 4'h9;
        codes.delete(); ctrs.delete();
        ack_en = 1'b0;
        for (int i = 0; i < 5; i++) send({18{v[i]}});
        chk("b2b_full_rdy", 32'(pkt_rdy), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_stalled_nsym", 32'(codes.size()), 32'd1);
        ack_en = 1'b1;
        wait_idle("b2b");
        chk("b2b_nsym", 32'(codes.size()), 32'd55);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("b2b_pkt%0d", i), 32'(seq_ok(11 * i, {18{v[i]}}, 1'b0)), 32'd1);
        end
        chk("b2b_pkt_count", pkt_count, 32'd8);
        chk("b2b_sym_count", sym_count, 32'd96);
    endtask

    task automatic test_timeout();
        logic [6:0] snap;
        codes.delete(); ctrs.delete();
        send(72'h0F1E2D3C4B5A697887);
        wait_syms(5, "to");
        ack_en = 1'b0;
        repeat (20) @(posedge clk);
        #1 snap = data_2of7;
        repeat (990) @(posedge clk);
        #1;
        chk("to_before_err", 32'(timeout_err), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("to_err_set", 32'(timeout_err), 32'd1);
        chk("to_data_stable", 32'(data_2of7), 32'(snap));
        chk("to_busy", 32'(busy), 32'd1);
        ack_en = 1'b1;
        wait_idle("to");
        chk("to_err_sticky", 32'(timeout_err), 32'd1);
        chk("to_seq", 32'(seq_ok(0, 72'h0F1E2D3C4B5A697887, 1'b1)), 32'd1);
        chk("to_pkt_count", pkt_count, 32'd9);
        timeout_clr = 1'b1;
        @(posedge clk); #1;
        timeout_clr = 1'b0;
        chk("to_err_clr", 32'(timeout_err), 32'd0);
    endtask

    task automatic test_enable();
        logic [6:0] snap;
        codes.delete(); ctrs.delete();
        snap   = data_2of7;
        enable = 1'b0;
        send({18{4'hC}});
        send({18{4'hD}});
        repeat (10) @(posedge clk);
        #1;
        chk("en_data_static", 32'(data_2of7), 32'(snap));
        chk("en_busy", 32'(busy), 32'd1);
        enable = 1'b1;
        @(posedge clk); #1;
        chk("en_first_sym", 32'(data_2of7), 32'(snap ^ code_of(4'hC)));
        wait_idle("en");
        chk("en_nsym", 32'(codes.size()), 32'd22);
        chk("en_seq0", 32'(seq_ok(0, {18{4'hC}}, 1'b0)), 32'd1);
        chk("en_seq1", 32'(seq_ok(11, {18{4'hD}}, 1'b0)), 32'd1);
        chk("en_pkt_count", pkt_count, 32'd11);
    endtask

    task automatic test_reset_mid();
        codes.delete(); ctrs.delete();
        send(72'h123456789ABCDEF0F2);
        wait_syms(5, "rmid");
        ack_en = 1'b0;
        rst    = 1'b1;
        @(posedge clk); #1;
        chk("rmid_data", 32'(data_2of7), 32'h00);
        chk("rmid_busy", 32'(busy), 32'd0);
        chk("rmid_pkt_rdy", 32'(pkt_rdy), 32'd0);
        chk("rmid_ctr", 32'(ctr_pkt), 32'd0);
        chk("rmid_pkt_count", pkt_count, 32'd0);
        chk("rmid_sym_count", sym_count, 32'd0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("rmid_fifo_empty", 32'(busy), 32'd0);
        rsp_prev = 7'h00;
        codes.delete(); ctrs.delete();
        ack_en = 1'b1;
        send(72'h000000000000000004);
        wait_idle("rmid");
        chk("rmid_seq", 32'(seq_ok(0, 72'h000000000000000004, 1'b0)), 32'd1);
        chk("rmid_new_pkt_count", pkt_count, 32'd1);
        chk("rmid_new_sym_count", sym_count, 32'd11);
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_short_payload();
        test_back_to_back();
        test_timeout();
        test_enable();
        test_reset_mid();
        chk("protocol_stray", 32'(stray), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
